stream_histogram: RTL and testbench
===================================

# stream_histogram

Parametrised multi-channel AXI-Stream histogram accumulator, the next generation of the histogram core behind the AXI-Lite register file. Each beat carries CH packed pixels of DATA_W bits. The block clears and accumulates one histogram per channel over a frame of TOTAL_PIXEL beats, then exposes the bins through a random-access read port. It reports IDLE/BUSY/DONE/ERROR with the same status encoding and a one-cycle completion pulse for the IRQ logic.

## Interface
- DATA_W, 8, pixel width; bins per channel = 2^DATA_W
- CH, 1, channels per beat (1..4)
- TOTAL_PIXEL, 256, beats per frame (W*H)
- CNT_W, $clog2(TOTAL_PIXEL+1), bin counter width; bins cannot overflow
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle command: begin clear + accumulate
- abort  in  1  one-cycle command: return to IDLE
- s_axis_tdata  in  CH*DATA_W  channel c in bits [c*DATA_W +: DATA_W]
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accepted when tvalid && tready
- s_axis_tlast  in  1  final beat of frame
- rd_en  in  1  bin read request
- rd_ch  in  max(1,$clog2(CH))  channel select
- rd_bin  in  DATA_W  bin select
- rd_valid  out  1  rd_data valid
- rd_data  out  CNT_W  bin count
- status  out  2  0 IDLE, 1 BUSY, 2 DONE, 3 ERROR
- err_code  out  2  0 none, 1 early tlast, 2 missing tlast
- done  out  1  one-cycle pulse on entering DONE or ERROR

## Operation
- Reset values: status=IDLE, s_axis_tready=0, done=0, err_code=0, rd_valid=0, rd_data=0. Bin RAM contents are not reset.
- IDLE/DONE/ERROR + start: enter BUSY clear phase. err_code is cleared. An address counter zeroes bin k of every channel in parallel, 0..2^DATA_W-1. tready=0 during this phase.
- BUSY accumulate phase: tready=1, one beat per cycle at full throughput. Each channel does a 2-stage read-modify-write (read bin, write bin+1).
- Same-bin hazards on back-to-back beats, or on beats two cycles apart, are forwarded. Each accepted pixel increments its bin exactly once regardless of repetition.
- A pixel counter counts accepted beats.
- Beat number TOTAL_PIXEL-1 with tlast=1: enter DONE after the pipeline drains.
- Same beat with tlast=0: enter ERROR with err_code=2. The beat is still counted.
- Any earlier beat with tlast=1: counted, then ERROR with err_code=1 after the drain.
- tready drops after the terminating beat.
- start while BUSY: ignored.
- abort in any state: IDLE on the next edge, tready=0, err_code unchanged. The pipeline is flushed and bin contents are undefined.
- start and abort in the same cycle: abort wins.
- Read port is active only in DONE or ERROR. rd_en there returns bin (rd_ch, rd_bin). rd_en elsewhere is ignored (rd_valid stays 0). rd_ch >= CH returns 0. Reads never modify bins.
- The sum over bins per channel equals the accepted beat count.

## Timing
- start sampled at edge N: status=BUSY after N; first tready=1 after edge N+2^DATA_W.
- Terminating beat accepted at edge M: tready=0 after M; status DONE/ERROR and done=1 after M+2; done=0 after M+3.
- rd_en at edge R: rd_valid=1 and rd_data valid after R, for one cycle. Back-to-back reads give back-to-back data.
- tvalid low stalls accumulation indefinitely with no timeout. The forwarding window counts accepted beats, not cycles.
- rst asserted mid-frame: immediate return to reset values.

## Test plan
- Reset, DATA_W=8, CH=1, TOTAL_PIXEL=256: status=0 and tready=0. start -> tready rises exactly 256 cycles later.
- 256 beats of values 0..255 in order, tlast on the last beat -> done pulse at M+2, status=2, every bin reads 1.
- 256 beats all 0x7F, continuous tvalid (forwarding stress) -> bin 0x7F=256, all others 0. Repeat with tvalid toggling every cycle for the same result.
- CH=3, tdata {c2,c1,c0}={0xFF,0x00,i[7:0]} -> ch0 all 1s, ch1 bin0=256, ch2 bin255=256.
- tlast on beat 100 -> status=3, err_code=1, sum of bins=101. A new frame with no tlast -> err_code=2, sum=256.
- abort at beat 50, then start and a full valid frame -> correct histogram with no residue from the aborted frame. start+abort in the same cycle -> IDLE.

Source files
------------

// File: rtl/stream_histogram.sv
// Multi-channel stream histogram: clears one bin RAM per channel, accumulates a frame of
// beats with a forwarded read-modify-write, then serves bins through a registered read port.
module stream_histogram #(
  parameter int DATA_W      = 8,
  parameter int CH          = 1,
  parameter int TOTAL_PIXEL = 256,
  parameter int CNT_W       = $clog2(TOTAL_PIXEL + 1),
  parameter int RD_CH_W     = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CH*DATA_W-1:0]   s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  input  logic                   rd_en,
  input  logic [RD_CH_W-1:0]     rd_ch,
  input  logic [DATA_W-1:0]      rd_bin,
  output logic                   rd_valid,
  output logic [CNT_W-1:0]       rd_data,
  output logic [1:0]             status,
  output logic [1:0]             err_code,
  output logic                   done
);

  localparam int BINS = 1 << DATA_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_EARLY = 2'd1;
  localparam logic [1:0] ERR_MISS  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACC,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   clr_addr;
  logic [CNT_W-1:0]    pix_cnt;
  logic                s1_v;
  logic                drain_cnt;
  logic [1:0]          pend_err;
  logic [RD_CH_W-1:0]  rd_ch_q;
  logic [CH*CNT_W-1:0] q_flat;

  // A beat transfers on a rising edge where s_axis_tvalid && s_axis_tready; tready is
  // registered and only high during the accumulate phase.
  logic accept;
  logic last_beat;
  logic clr_we;
  logic rd_sel;

  assign accept    = s_axis_tvalid && s_axis_tready;
  assign last_beat = (pix_cnt == CNT_W'(TOTAL_PIXEL - 1));
  assign clr_we    = (state == S_CLEAR);
  assign rd_sel    = (state == S_DONE) || (state == S_ERROR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      status        <= ST_IDLE;
      s_axis_tready <= 1'b0;
      done          <= 1'b0;
      err_code      <= ERR_NONE;
      clr_addr      <= '0;
      pix_cnt       <= '0;
      s1_v          <= 1'b0;
      drain_cnt     <= 1'b0;
      pend_err      <= ERR_NONE;
      rd_valid      <= 1'b0;
      rd_ch_q       <= '0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      s1_v     <= 1'b0;
      if (abort) begin
        state         <= S_IDLE;
        status        <= ST_IDLE;
        s_axis_tready <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_ERROR: begin
            if (state != S_IDLE) begin
              rd_valid <= rd_en;
              rd_ch_q  <= rd_ch;
            end
            if (start) begin
              state    <= S_CLEAR;
              status   <= ST_BUSY;
              err_code <= ERR_NONE;
              clr_addr <= '0;
              pix_cnt  <= '0;
            end
          end
          S_CLEAR: begin
            clr_addr <= clr_addr + DATA_W'(1);
            if (clr_addr == '1) begin
              state         <= S_ACC;
              s_axis_tready <= 1'b1;
            end
          end
          S_ACC: begin
            if (accept) begin
              s1_v    <= 1'b1;
              pix_cnt <= pix_cnt + CNT_W'(1);
              if (last_beat || s_axis_tlast) begin
                s_axis_tready <= 1'b0;
                state         <= S_DRAIN;
                drain_cnt     <= 1'b0;
                if (!last_beat)        pend_err <= ERR_EARLY;
                else if (!s_axis_tlast) pend_err <= ERR_MISS;
                else                   pend_err <= ERR_NONE;
              end
            end
          end
          S_DRAIN: begin
            drain_cnt <= 1'b1;
            if (drain_cnt) begin
              state    <= (pend_err == ERR_NONE) ? S_DONE : S_ERROR;
              status   <= (pend_err == ERR_NONE) ? ST_DONE : ST_ERROR;
              err_code <= pend_err;
              done     <= 1'b1;
            end
          end
          default: begin
            state  <= S_IDLE;
            status <= ST_IDLE;
          end
        endcase
      end
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [CNT_W-1:0]  mem [BINS];
    logic [CNT_W-1:0]  mem_q;
    logic [CNT_W-1:0]  fwd_val;
    logic [CNT_W-1:0]  w_new;
    logic [DATA_W-1:0] pix;
    logic [DATA_W-1:0] s1_pix;
    logic              fwd_hit;

    assign pix   = s_axis_tdata[c*DATA_W +: DATA_W];
    // The RAM read for a beat misses only the write of the beat just before it.
    assign w_new = (fwd_hit ? fwd_val : mem_q) + CNT_W'(1);
    assign q_flat[c*CNT_W +: CNT_W] = mem_q;

    always_ff @(posedge clk) begin
      if (clr_we)    mem[clr_addr] <= '0;
      else if (s1_v) mem[s1_pix]   <= w_new;
      mem_q <= mem[rd_sel ? rd_bin : pix];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_pix  <= '0;
        fwd_hit <= 1'b0;
        fwd_val <= '0;
      end else if (accept) begin
        s1_pix  <= pix;
        fwd_hit <= s1_v && (s1_pix == pix);
        fwd_val <= w_new;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < CH; c++) begin
      if (rd_valid && (rd_ch_q == RD_CH_W'(c))) rd_data = q_flat[c*CNT_W +: CNT_W];
    end
  end

endmodule

// File: tb/tb_stream_histogram.sv
// Bench for stream_histogram (3 channels, 8-bit pixels, 256-beat frames): directed frames,
// a histogram model fed by the driver and a per-cycle compare of every output.
module tb_stream_histogram;
  localparam int DATA_W      = 8;
  localparam int CH          = 3;
  localparam int TOTAL_PIXEL = 256;
  localparam int CNT_W       = $clog2(TOTAL_PIXEL + 1);
  localparam int RD_CH_W     = 2;
  localparam int BINS        = 256;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic [CH*DATA_W-1:0] s_axis_tdata = '0;
  logic                 s_axis_tvalid = 1'b0;
  logic                 s_axis_tlast = 1'b0;
  logic                 s_axis_tready;
  logic                 rd_en = 1'b0;
  logic [RD_CH_W-1:0]   rd_ch = '0;
  logic [DATA_W-1:0]    rd_bin = '0;
  logic                 rd_valid;
  logic [CNT_W-1:0]     rd_data;
  logic [1:0]           status;
  logic [1:0]           err_code;
  logic                 done;

  stream_histogram #(.DATA_W(DATA_W), .CH(CH), .TOTAL_PIXEL(TOTAL_PIXEL)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_bin(rd_bin),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .status(status), .err_code(err_code), .done(done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- model and scoreboard state ----------------
  int               n_checks = 0;
  int               n_fail = 0;
  int               hist [CH][BINS];
  logic [1:0]       exp_status = 2'd0;
  logic [1:0]       exp_err = 2'd0;
  logic             exp_tready = 1'b0;
  logic             exp_done = 1'b0;
  logic             exp_rd_valid = 1'b0;
  logic [CNT_W-1:0] exp_q [$];
  int               exp_ch_q [$];
  int               rd_sum [4];
  bit               check_en = 1'b0;
  logic [CNT_W-1:0] e_val;
  int               e_ch;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] pix(input int fid, input int c, input int i);
    case (fid)
      1:       return (c == 0) ? 8'(i) : ((c == 1) ? 8'h00 : 8'hFF);
      2, 3:    return 8'h7F;
      4:       return 8'(i * 37 + c * 11);
      5:       return 8'(i * 5 + c);
      default: begin
        if (c == 0)      return (((i >> 1) & 1) != 0) ? 8'h10 : 8'h20;
        else if (c == 1) return 8'(i & 3);
        else             return ((i & 1) != 0) ? 8'h33 : 8'h44;
      end
    endcase
  endfunction

  function automatic int model_sum(input int c);
    int s = 0;
    for (int b = 0; b < BINS; b++) s += hist[c][b];
    return s;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (check_en) begin
      check("status", status, exp_status);
      check("tready", s_axis_tready, exp_tready);
      check("done", done, exp_done);
      check("err_code", err_code, exp_err);
      check("rd_valid", rd_valid, exp_rd_valid);
      if (exp_rd_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_queue: no expected entry, rd_valid=%0b", rd_valid);
        end else begin
          e_val = exp_q.pop_front();
          e_ch  = exp_ch_q.pop_front();
          check("rd_data", rd_data, e_val);
          rd_sum[e_ch] += int'(rd_data);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_status = 2'd1;
    exp_tready = 1'b0;
    exp_err    = 2'd0;
    foreach (hist[c, b]) hist[c][b] = 0;
    rd_en = 1'b1;  // read while busy must be ignored
    tick();
    rd_en = 1'b0;
    for (int k = 1; k < BINS - 1; k++) tick();
    tick();
    exp_tready = 1'b1;
  endtask

  task automatic send_frame(input int fid, input int nbeats, input int tlast_at,
                            input bit toggle, input int abort_at);
    int code;
    for (int i = 0; i < nbeats; i++) begin
      if (i == abort_at) begin
        s_axis_tvalid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_status = 2'd0;
        exp_tready = 1'b0;
        return;
      end
      if (toggle) begin
        s_axis_tvalid = 1'b0;
        if (i == 10) start = 1'b1;  // start while busy is ignored
        tick();
        start = 1'b0;
      end
      s_axis_tdata  = {pix(fid, 2, i), pix(fid, 1, i), pix(fid, 0, i)};
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == tlast_at);
      tick();
      for (int c = 0; c < CH; c++) hist[c][pix(fid, c, i)]++;
      if (i == tlast_at || i == TOTAL_PIXEL - 1) begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        exp_tready    = 1'b0;
        if (i == TOTAL_PIXEL - 1 && i == tlast_at) code = 0;
        else if (i == TOTAL_PIXEL - 1)             code = 2;
        else                                       code = 1;
        tick();
        tick();
        exp_status = (code == 0) ? 2'd2 : 2'd3;
        exp_err    = 2'(code);
        exp_done   = 1'b1;
        tick();
        exp_done   = 1'b0;
        return;
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic read_all();
    for (int c = 0; c < 4; c++) rd_sum[c] = 0;
    for (int c = 0; c < 4; c++) begin
      for (int b = 0; b < BINS; b++) begin
        rd_en  = 1'b1;
        rd_ch  = 2'(c);
        rd_bin = 8'(b);
        tick();
        exp_q.push_back((c < CH) ? CNT_W'(hist[c][b]) : '0);
        exp_ch_q.push_back(c);
        exp_rd_valid = 1'b1;
      end
    end
    rd_en = 1'b0;
    tick();
    exp_rd_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1;
    check("reset_status", status, 2'd0);
    check("reset_tready", s_axis_tready, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_err", err_code, 2'd0);
    check("reset_rd_valid", rd_valid, 1'b0);
    check("reset_rd_data", rd_data, 0);
    @(negedge clk);
    rst = 1'b0;
    check_en = 1'b1;
    tick();

    // ramp in ch0, constants in ch1/ch2
    do_start();
    send_frame(1, TOTAL_PIXEL, TOTAL_PIXEL - 1, 1'b0, -1);
    read_all();
    check("m1_ch0_bin200", hist[0][200], 1);
    check("m1_ch1_bin0", hist[1][0], 256);
    check("m1_ch2_bin255", hist[2][255], 256);
    check("f1_sum_ch0", rd_sum[0], 256);
    check("f1_sum_ch1", rd_sum[1], 256);
    check("f1_sum_ch3", rd_sum[3], 0);

    // same bin every beat, continuous then with tvalid toggling
    do_start();
    send_frame(2, TOTAL_PIXEL, TOTAL_PIXEL - 1, 1'b0, -1);
    read_all();
    check("m2_bin7f", hist[0][8'h7F], 256);
    check("f2_sum_ch0", rd_sum[0], 256);
    check("f2_sum_ch2", rd_sum[2], 256);

    do_start();
    send_frame(3, TOTAL_PIXEL, TOTAL_PIXEL - 1, 1'b1, -1);
    read_all();
    check("f3_sum_ch0", rd_sum[0], 256);

    // early tlast on beat 100, then a frame without tlast
    do_start();
    send_frame(4, TOTAL_PIXEL, 100, 1'b0, -1);
    read_all();
    check("m4_sum", model_sum(0), 101);
    check("f4_sum_ch0", rd_sum[0], 101);
    check("f4_sum_ch2", rd_sum[2], 101);

    do_start();
    send_frame(5, TOTAL_PIXEL, -1, 1'b0, -1);
    read_all();
    check("f5_sum_ch1", rd_sum[1], 256);

    // abort mid-frame, read in IDLE is ignored, then a clean frame
    do_start();
    send_frame(6, TOTAL_PIXEL, TOTAL_PIXEL - 1, 1'b0, 50);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tick();
    do_start();
    send_frame(7, TOTAL_PIXEL, TOTAL_PIXEL - 1, 1'b0, -1);
    read_all();
    check("m7_ch0_bin10", hist[0][8'h10], 128);
    check("m7_ch1_bin2", hist[1][2], 64);
    check("m7_ch2_bin33", hist[2][8'h33], 128);
    check("f7_sum_ch0", rd_sum[0], 256);
    check("f7_sum_ch1", rd_sum[1], 256);

    // start and abort together from DONE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    exp_status = 2'd0;
    exp_tready = 1'b0;
    for (int k = 0; k < 4; k++) tick();

    // asynchronous reset in the middle of a frame
    do_start();
    send_frame(5, 5, -1, 1'b0, -1);
    exp_status = 2'd0;
    exp_tready = 1'b0;
    exp_err    = 2'd0;
    rst = 1'b1;
    #1;
    check("midrst_status", status, 2'd0);
    check("midrst_tready", s_axis_tready, 1'b0);
    check("midrst_done", done, 1'b0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) tick();

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
